// File: rtl/controlador_bus_rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer.
//   - state_t        : bus-cycle states (IDLE, address phases, data phases, FIN)
//   - BUS_W          : AD bus / register width
//   - PHASE_LEN_MIN/MAX : legal cycles-per-phase range (3-bit step counter)
//   - CMD_WRITE/READ : encoding of the wr_rd command bit
package controlador_bus_rtc_pkg;

  localparam int unsigned BUS_W         = 8;
  localparam int unsigned PHASE_LEN_MIN = 1;
  localparam int unsigned PHASE_LEN_MAX = 7;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    FIN
  } state_t;

  function automatic logic is_addr_phase(state_t s);
    return (s == A_SETUP) || (s == A_STROBE) || (s == A_HOLD);
  endfunction

  function automatic logic is_data_phase(state_t s);
    return (s == D_SETUP) || (s == D_STROBE) || (s == D_HOLD);
  endfunction

endpackage

// File: rtl/controlador_bus_rtc_if.sv
// Command and AD-bus bundle for controlador_bus_rtc.
//   Command side : start, wr_rd, addr, data_in -> busy, done, data_out
//   Pad side     : ad_in -> cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
// modport slave is taken by the sequencer, master by whoever drives it.
interface controlador_bus_rtc_if;
  import controlador_bus_rtc_pkg::*;

  logic             start;
  logic             wr_rd;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] data_in;
  logic [BUS_W-1:0] ad_in;
  logic             busy;
  logic             done;
  logic [BUS_W-1:0] data_out;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic             ad_n;
  logic [BUS_W-1:0] ad_out;
  logic             ad_oe;

  modport master (
    output start, wr_rd, addr, data_in, ad_in,
    input  busy, done, data_out, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
  );

  modport slave (
    input  start, wr_rd, addr, data_in, ad_in,
    output busy, done, data_out, cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
  );

endinterface

// File: rtl/controlador_bus_rtc_contador_fase.sv
// Per-phase step counter for the bus sequencer.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : restart the count at 0 (has priority over en_i)
//   en_i       : advance the count by one
//   tc_o       : count has reached PHASE_LEN-1 (last cycle of the phase)
module contador_fase #(
  parameter int unsigned PHASE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [2:0] TC_VAL = 3'(PHASE_LEN - 1);

  logic [2:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 3'd1;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/controlador_bus_rtc.sv
// Six-phase read/write sequencer for the RTC multiplexed AD bus.
//   clk, reset : clock, synchronous active-high reset
//   bus        : controlador_bus_rtc_if.slave (command handshake + pad signals)
// One command is accepted in IDLE; the bus then runs address setup/strobe/hold
// and data setup/strobe/hold, each PHASE_LEN cycles, followed by a one-cycle FIN.
module controlador_bus_rtc
  import controlador_bus_rtc_pkg::*;
#(
  parameter int unsigned PHASE_LEN = 4
) (
  input logic                 clk,
  input logic                 reset,
  controlador_bus_rtc_if.slave bus
);

  state_t           state_q, state_d;
  logic             cmd_q, cmd_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] data_q, data_d;

  logic             cs_n_q, rd_n_q, wr_n_q, ad_n_q, ad_oe_q;
  logic [BUS_W-1:0] ad_out_q, data_out_q;
  logic             busy_q, done_q;

  logic tc, cnt_en, cnt_clr;

  // Counter runs in every bus phase and restarts on accept and at each phase boundary.
  assign cnt_en  = (state_q != IDLE) && (state_q != FIN);
  assign cnt_clr = ((state_q == IDLE) && bus.start) || (cnt_en && tc);

  contador_fase #(.PHASE_LEN(PHASE_LEN)) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = A_SETUP;
          cmd_d   = bus.wr_rd;
          addr_d  = bus.addr;
          data_d  = bus.data_in;
        end
      end
      A_SETUP:  if (tc) state_d = A_STROBE;
      A_STROBE: if (tc) state_d = A_HOLD;
      A_HOLD:   if (tc) state_d = D_SETUP;
      D_SETUP:  if (tc) state_d = D_STROBE;
      D_STROBE: if (tc) state_d = D_HOLD;
      D_HOLD:   if (tc) state_d = FIN;
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and next command latches so each
  // registered output lines up with the state it describes in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_READ;
      addr_q     <= '0;
      data_q     <= '0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_n_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;

      cs_n_q  <= (state_d == IDLE) || (state_d == FIN);
      ad_n_q  <= !is_addr_phase(state_d);
      wr_n_q  <= !((state_d == A_STROBE) ||
                   ((state_d == D_STROBE) && (cmd_d == CMD_WRITE)));
      rd_n_q  <= !((state_d == D_STROBE) && (cmd_d == CMD_READ));
      ad_oe_q <= is_addr_phase(state_d) ||
                 (is_data_phase(state_d) && (cmd_d == CMD_WRITE));

      if (is_addr_phase(state_d)) begin
        ad_out_q <= addr_d;
      end else if (is_data_phase(state_d) && (cmd_d == CMD_WRITE)) begin
        ad_out_q <= data_d;
      end else begin
        ad_out_q <= '0;
      end

      busy_q <= (state_d != IDLE);
      done_q <= (state_d == FIN);

      // Sample the pad on the final strobe cycle, while rd_n is still low.
      if ((state_q == D_STROBE) && tc && (cmd_q == CMD_READ)) begin
        data_out_q <= bus.ad_in;
      end
    end
  end

  // The step counter is 3 bits wide, so PHASE_LEN must stay in 1..7.
  always_ff @(posedge clk) begin
    assert (PHASE_LEN >= PHASE_LEN_MIN && PHASE_LEN <= PHASE_LEN_MAX);
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.ad_n     = ad_n_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_controlador_bus_rtc.sv
// Bench for controlador_bus_rtc: a PHASE_LEN=4 and a PHASE_LEN=1 instance share
// the same command/pad stimulus; a cycle-index model predicts every output.
module tb_controlador_bus_rtc;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic       ad_oe;
    logic [7:0] ad_out;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, wr_rd;
  logic [7:0] addr, data_in, ad_in;

  controlador_bus_rtc_if if4 ();
  controlador_bus_rtc_if if1 ();

  assign if4.start = start;   assign if1.start = start;
  assign if4.wr_rd = wr_rd;   assign if1.wr_rd = wr_rd;
  assign if4.addr = addr;     assign if1.addr = addr;
  assign if4.data_in = data_in; assign if1.data_in = data_in;
  assign if4.ad_in = ad_in;   assign if1.ad_in = ad_in;

  controlador_bus_rtc #(.PHASE_LEN(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
  controlador_bus_rtc #(.PHASE_LEN(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // Model: k = cycles since accept (0 = idle, 1..6*pl bus phases, 6*pl+1 = FIN).
  int unsigned pl [2] = '{4, 1};
  int unsigned k  [2];
  logic        m_cmd  [2];
  logic [7:0]  m_addr [2];
  logic [7:0]  m_data [2];
  logic [7:0]  m_dout [2];

  int tests = 0;
  int fails = 0;

  function automatic obs_t expected(int i);
    obs_t v;
    int unsigned p;
    v = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
          ad_n: 1'b1, ad_oe: 1'b0, ad_out: 8'h00};
    if (k[i] == 6 * pl[i] + 1) begin
      v.busy = 1'b1;
      v.done = 1'b1;
    end else if (k[i] != 0) begin
      p = (k[i] - 1) / pl[i];
      v.busy = 1'b1;
      v.cs_n = 1'b0;
      if (p < 3) begin
        v.ad_n = 1'b0;
        v.ad_oe = 1'b1;
        v.ad_out = m_addr[i];
        if (p == 1) v.wr_n = 1'b0;
      end else begin
        if (m_cmd[i]) begin
          v.ad_oe = 1'b1;
          v.ad_out = m_data[i];
          if (p == 4) v.wr_n = 1'b0;
        end else if (p == 4) begin
          v.rd_n = 1'b0;
        end
      end
    end
    return v;
  endfunction

  function automatic obs_t observed(int i);
    if (i == 0)
      return {if4.busy, if4.done, if4.cs_n, if4.rd_n, if4.wr_n, if4.ad_n, if4.ad_oe, if4.ad_out};
    else
      return {if1.busy, if1.done, if1.cs_n, if1.rd_n, if1.wr_n, if1.ad_n, if1.ad_oe, if1.ad_out};
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s pl=%0d: observed %h expected %h", tag, pl[i], obs, exp);
    end
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare #1 after.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i] = 0;
        m_dout[i] = 8'h00;
      end else if (k[i] == 0) begin
        if (start) begin
          k[i] = 1;
          m_cmd[i] = wr_rd;
          m_addr[i] = addr;
          m_data[i] = data_in;
        end
      end else begin
        if (k[i] == 5 * pl[i] && !m_cmd[i]) m_dout[i] = ad_in;
        k[i] = (k[i] == 6 * pl[i] + 1) ? 0 : k[i] + 1;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("bus", i, 32'(observed(i)), 32'(expected(i)));
      chk("data_out", i, 32'(i == 0 ? if4.data_out : if1.data_out), 32'(m_dout[i]));
    end
  endtask

  // One command, start high for the first cycle only; reports busy length and done position.
  task automatic txn(input logic cmd, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] adv, input int n,
                     output int b4, output int d4, output int b1, output int d1);
    wr_rd = cmd; addr = a; data_in = d; ad_in = adv;
    b4 = 0; d4 = 0; b1 = 0; d1 = 0;
    for (int j = 1; j <= n; j++) begin
      start = (j == 1);
      step();
      if (if4.busy) b4++;
      if (if1.busy) b1++;
      if (if4.done && d4 == 0) d4 = j;
      if (if1.done && d1 == 0) d1 = j;
    end
    start = 1'b0;
  endtask

  initial begin
    int b4, d4, b1, d1;
    int q4[$];
    int q1[$];
    int dcount;

    reset = 1'b1; start = 1'b0; wr_rd = 1'b0;
    addr = 8'h00; data_in = 8'h00; ad_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; m_cmd[i] = 1'b0; m_addr[i] = 8'h00; m_data[i] = 8'h00; m_dout[i] = 8'h00;
    end
    step();
    step();
    reset = 1'b0;
    step();

    // Write 0x59 to 0x21.
    txn(1'b1, 8'h21, 8'h59, 8'h00, 30, b4, d4, b1, d1);
    chk("wr_busy_len", 0, 32'(b4), 32'd25);
    chk("wr_done_pos", 0, 32'(d4), 32'd25);
    chk("wr_busy_len", 1, 32'(b1), 32'd7);
    chk("wr_done_pos", 1, 32'(d1), 32'd7);

    // Read 0x22 with the pad returning 0x37.
    txn(1'b0, 8'h22, 8'hFF, 8'h37, 30, b4, d4, b1, d1);
    chk("rd_busy_len", 0, 32'(b4), 32'd25);
    chk("rd_result", 0, 32'(if4.data_out), 32'h37);
    chk("rd_result", 1, 32'(if1.data_out), 32'h37);

    // Read 0xA5, then a write must leave data_out alone.
    txn(1'b0, 8'h30, 8'h00, 8'hA5, 30, b4, d4, b1, d1);
    ad_in = 8'h3C;
    txn(1'b1, 8'h31, 8'h77, 8'h3C, 30, b4, d4, b1, d1);
    chk("wr_keeps_dout", 0, 32'(if4.data_out), 32'hA5);
    chk("wr_keeps_dout", 1, 32'(if1.data_out), 32'hA5);

    // start held high: back-to-back commands with one IDLE cycle between them.
    wr_rd = 1'b0; addr = 8'h40; data_in = 8'h12;
    start = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      ad_in = 8'($urandom_range(0, 255));
      step();
      if (if4.done) q4.push_back(j);
      if (if1.done) q1.push_back(j);
    end
    start = 1'b0;
    chk("b2b_count", 0, 32'(q4.size()), 32'd2);
    if (q4.size() >= 2) chk("b2b_period", 0, 32'(q4[1] - q4[0]), 32'd26);
    if (q1.size() >= 2) chk("b2b_period", 1, 32'(q1[1] - q1[0]), 32'd8);
    for (int j = 0; j < 30; j++) step();

    // A second start pulse mid-transaction is ignored by the PL=4 instance.
    wr_rd = 1'b1; addr = 8'h50; data_in = 8'h66;
    dcount = 0;
    for (int j = 1; j <= 40; j++) begin
      start = (j == 1) || (j == 10);
      step();
      if (if4.done) dcount++;
    end
    start = 1'b0;
    chk("ignored_start", 0, 32'(dcount), 32'd1);

    // Reset in D_STROBE of a read: bus released, result cleared, no done.
    txn(1'b0, 8'h55, 8'h00, 8'hA5, 30, b4, d4, b1, d1);
    wr_rd = 1'b0; addr = 8'h66; ad_in = 8'hC3;
    for (int j = 1; j <= 18; j++) begin
      start = (j == 1);
      step();
    end
    chk("pre_reset_rd_n", 0, 32'(if4.rd_n), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_rd_n", 0, 32'(if4.rd_n), 32'd1);
    chk("rst_cs_n", 0, 32'(if4.cs_n), 32'd1);
    chk("rst_ad_oe", 0, 32'(if4.ad_oe), 32'd0);
    chk("rst_busy", 0, 32'(if4.busy), 32'd0);
    chk("rst_dout", 0, 32'(if4.data_out), 32'd0);
    dcount = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (if4.done) dcount++;
    end
    chk("rst_no_done", 0, 32'(dcount), 32'd0);

    // Randomised traffic with occasional resets.
    for (int j = 0; j < 600; j++) begin
      reset   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 3) == 0);
      wr_rd   = 1'($urandom_range(0, 1));
      addr    = 8'($urandom_range(0, 255));
      data_in = 8'($urandom_range(0, 255));
      ad_in   = 8'($urandom_range(0, 255));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
